// File: rtl/spm_wb_arbiter_if.sv
// Byte-wide Wishbone link used between the masters, the arbiter and the scratchpad.
// The mem_* modports omit err because the scratchpad slave never signals errors.
interface spm_wb_arbiter_if #(
  parameter int unsigned AW = 10
);
  logic [AW-1:0] adr;
  logic [7:0]    dat_w;
  logic [7:0]    dat_r;
  logic          we;
  logic          cyc;
  logic          stb;
  logic          ack;
  logic          err;

  modport master (
    output adr, dat_w, we, cyc, stb,
    input  dat_r, ack, err
  );

  modport slave (
    input  adr, dat_w, we, cyc, stb,
    output dat_r, ack, err
  );

  modport mem_master (
    output adr, dat_w, we, cyc, stb,
    input  dat_r, ack
  );

  modport mem_slave (
    input  adr, dat_w, we, cyc, stb,
    output dat_r, ack
  );
endinterface

// File: rtl/spm_wb_arbiter.sv
// Round-robin two-master Wishbone arbiter for the scratchpad; grant is held for a
// whole CYC and a per-transfer watchdog aborts stalled strobes with an err pulse.
module spm_wb_arbiter #(
  parameter int unsigned SPM_AWID = 10,
  parameter int unsigned TIMEOUT  = 16,
  parameter int unsigned TO_W     = $clog2(TIMEOUT + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  spm_wb_arbiter_if.slave      m0,
  spm_wb_arbiter_if.slave      m1,
  spm_wb_arbiter_if.mem_master s,
  output logic [1:0]           gnt_o
);

  // TIMEOUT=0 yields a zero-width counter; keep one dummy bit that stays at 0.
  localparam int unsigned WD_W = (TO_W > 0) ? TO_W : 1;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    ABORT
  } state_e;

  state_e          state_q, state_d;
  logic            owner_q, owner_d;
  logic            last_owner_q, last_owner_d;
  logic [WD_W-1:0] wdog_q, wdog_d;

  logic [1:0]          cyc, stb, we;
  logic [SPM_AWID-1:0] adr [2];
  logic [7:0]          wdat [2];
  logic [7:0]          rdat [2];
  logic [1:0]          ack, err;
  logic                own_cyc, own_stb;

  assign cyc     = {m1.cyc, m0.cyc};
  assign stb     = {m1.stb, m0.stb};
  assign we      = {m1.we, m0.we};
  assign adr[0]  = m0.adr;
  assign adr[1]  = m1.adr;
  assign wdat[0] = m0.dat_w;
  assign wdat[1] = m1.dat_w;

  assign m0.ack   = ack[0];
  assign m0.err   = err[0];
  assign m0.dat_r = rdat[0];
  assign m1.ack   = ack[1];
  assign m1.err   = err[1];
  assign m1.dat_r = rdat[1];

  assign own_cyc = cyc[owner_q];
  assign own_stb = stb[owner_q];

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    wdog_d       = '0;
    gnt_o        = '0;
    s.adr        = '0;
    s.dat_w      = '0;
    s.we         = 1'b0;
    s.cyc        = 1'b0;
    s.stb        = 1'b0;
    ack          = '0;
    err          = '0;
    rdat[0]      = '0;
    rdat[1]      = '0;

    unique case (state_q)
      IDLE: begin
        if (|cyc) begin
          state_d = GRANT;
          owner_d = (&cyc) ? ~last_owner_q : cyc[1];
        end
      end

      GRANT: begin
        gnt_o[owner_q] = 1'b1;
        s.adr          = adr[owner_q];
        s.dat_w        = wdat[owner_q];
        s.we           = we[owner_q];
        s.cyc          = own_cyc;
        s.stb          = own_stb;
        ack[owner_q]   = s.ack;
        rdat[owner_q]  = s.dat_r;

        if (!own_cyc) begin
          state_d      = IDLE;
          last_owner_d = owner_q;
        end else if (TIMEOUT > 0 && own_stb && !s.ack) begin
          // An ack in the final cycle clears the counter above, so it beats the abort.
          if (wdog_q == WD_W'(TIMEOUT - 1)) begin
            err[owner_q] = 1'b1;
            state_d      = ABORT;
          end else begin
            wdog_d = wdog_q + 1'b1;
          end
        end
      end

      ABORT: begin
        if (!own_cyc) begin
          state_d      = IDLE;
          last_owner_d = owner_q;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      wdog_q       <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      wdog_q       <= wdog_d;
    end
  end

endmodule

// File: tb/tb_spm_wb_arbiter.sv
// Bench for spm_wb_arbiter: directed scenarios plus random traffic, every cycle
// compared against an ownership-level reference model of the arbitration rules.
module tb_spm_wb_arbiter;

  localparam int unsigned AW = 10;
  localparam int          TO = 4;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] gnt;

  always #5 clk = ~clk;

  spm_wb_arbiter_if #(.AW(AW)) m0_bus ();
  spm_wb_arbiter_if #(.AW(AW)) m1_bus ();
  spm_wb_arbiter_if #(.AW(AW)) s_bus ();

  spm_wb_arbiter #(
    .SPM_AWID(AW),
    .TIMEOUT (TO)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .m0   (m0_bus),
    .m1   (m1_bus),
    .s    (s_bus),
    .gnt_o(gnt)
  );

  logic          c  [2];
  logic          st [2];
  logic          w  [2];
  logic [AW-1:0] a  [2];
  logic [7:0]    d  [2];

  assign m0_bus.cyc   = c[0];
  assign m0_bus.stb   = st[0];
  assign m0_bus.we    = w[0];
  assign m0_bus.adr   = a[0];
  assign m0_bus.dat_w = d[0];
  assign m1_bus.cyc   = c[1];
  assign m1_bus.stb   = st[1];
  assign m1_bus.we    = w[1];
  assign m1_bus.adr   = a[1];
  assign m1_bus.dat_w = d[1];

  // Scratchpad stand-in: ack one cycle after a fresh strobe unless stalled.
  logic [7:0] mem [1024];
  logic       stall;

  always @(posedge clk) begin
    if (rst) begin
      s_bus.ack   <= 1'b0;
      s_bus.dat_r <= 8'h00;
    end else if (s_bus.cyc && s_bus.stb && !s_bus.ack && !stall) begin
      s_bus.ack <= 1'b1;
      if (s_bus.we) begin
        mem[s_bus.adr] <= s_bus.dat_w;
        s_bus.dat_r    <= s_bus.dat_w;
      end else begin
        s_bus.dat_r <= mem[s_bus.adr];
      end
    end else begin
      s_bus.ack <= 1'b0;
    end
  end

  // Reference model: who owns the bus (-1 none), whether it is aborted,
  // who wins the next contention, and how long the owner's strobe has waited.
  int own, pref, waited;
  bit abt;

  int unsigned n_vec, n_bad, cyc_no;

  logic [1:0] ob_ack, ob_err, ob_gnt;
  logic [7:0] ob_dat [2];
  logic       ob_scyc, ob_sstb;

  task automatic tick();
    logic [42:0] got, exp;
    logic [1:0]  eg, ea, ee;
    logic        ecyc, estb, ewe, sack;
    logic [AW-1:0] eadr;
    logic [7:0]  edw, ed0, ed1;
    bit          granted, to_now;
    @(negedge clk);
    sack    = s_bus.ack;
    granted = (own >= 0) && !abt;
    eg = '0; ea = '0; ee = '0;
    ecyc = 1'b0; estb = 1'b0; ewe = 1'b0; eadr = '0; edw = '0; ed0 = '0; ed1 = '0;
    to_now = 1'b0;
    if (granted) begin
      eg[own] = 1'b1;
      ecyc    = c[own];
      estb    = st[own];
      ewe     = w[own];
      eadr    = a[own];
      edw     = d[own];
      ea[own] = sack;
      if (own == 0) ed0 = s_bus.dat_r;
      else          ed1 = s_bus.dat_r;
      to_now  = c[own] && st[own] && !sack && (waited == TO - 1);
      if (to_now) ee[own] = 1'b1;
    end
    got = {gnt, s_bus.cyc, s_bus.stb, s_bus.we, s_bus.adr, s_bus.dat_w,
           m0_bus.ack, m0_bus.err, m0_bus.dat_r, m1_bus.ack, m1_bus.err, m1_bus.dat_r};
    exp = {eg, ecyc, estb, ewe, eadr, edw, ea[0], ee[0], ed0, ea[1], ee[1], ed1};
    n_vec++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL cycle_%0d outputs got=%h exp=%h", cyc_no, got, exp);
    end
    ob_ack  = {m1_bus.ack, m0_bus.ack};
    ob_err  = {m1_bus.err, m0_bus.err};
    ob_gnt  = gnt;
    ob_dat[0] = m0_bus.dat_r;
    ob_dat[1] = m1_bus.dat_r;
    ob_scyc = s_bus.cyc;
    ob_sstb = s_bus.stb;

    if (rst) begin
      own = -1; abt = 1'b0; pref = 0; waited = 0;
    end else if (own < 0) begin
      if (c[0] && c[1]) own = pref;
      else if (c[0])    own = 0;
      else if (c[1])    own = 1;
    end else if (!c[own]) begin
      pref = 1 - own; own = -1; abt = 1'b0; waited = 0;
    end else if (!abt) begin
      if (to_now) begin
        abt = 1'b1; waited = 0;
      end else if (st[own] && !sack) begin
        waited++;
      end else begin
        waited = 0;
      end
    end
    cyc_no++;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_ack(input int m, output int n);
    n = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      n++;
      if (ob_ack[m] || ob_err[m]) return;
    end
    n_vec++;
    n_bad++;
    $error("FAIL wait_ack_m%0d got=no_ack exp=ack", m);
  endtask

  task automatic release_all();
    for (int i = 0; i < 2; i++) begin
      c[i] = 1'b0; st[i] = 1'b0;
    end
    repeat (3) tick();
  endtask

  initial begin
    int lat, nstb, cnt0;
    logic [1:0] prev;
    logic [1:0] seq [$];

    n_vec = 0; n_bad = 0; cyc_no = 0;
    own = -1; abt = 1'b0; pref = 0; waited = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    for (int i = 0; i < 2; i++) begin
      c[i] = 1'b0; st[i] = 1'b0; w[i] = 1'b0; a[i] = '0; d[i] = '0;
    end
    stall = 1'b0;
    rst   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    chk("reset_gnt", {30'd0, ob_gnt}, 32'd0);

    // Single write then read by m0
    c[0] = 1'b1; st[0] = 1'b1; w[0] = 1'b1; a[0] = 10'h005; d[0] = 8'hA5;
    wait_ack(0, lat);
    chk("wr_latency", lat, 3);
    w[0] = 1'b0;
    wait_ack(0, lat);
    chk("rd_latency", lat, 2);
    chk("rd_data", {24'd0, ob_dat[0]}, 32'hA5);
    release_all();

    // Simultaneous first request after reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    c[0] = 1'b1; st[0] = 1'b1; w[0] = 1'b1; a[0] = 10'h010; d[0] = 8'h01;
    c[1] = 1'b1; st[1] = 1'b1; w[1] = 1'b1; a[1] = 10'h020; d[1] = 8'h02;
    tick();
    tick();
    chk("contend_first", {30'd0, ob_gnt}, 32'd1);
    wait_ack(0, lat);
    c[0] = 1'b0; st[0] = 1'b0;
    tick();
    tick();
    chk("contend_bubble", {30'd0, ob_gnt}, 32'd0);
    tick();
    chk("contend_second", {30'd0, ob_gnt}, 32'd2);
    wait_ack(1, lat);
    release_all();

    // Continuous contention: one ack per grant, immediate re-request
    seq.delete();
    prev = 2'b00;
    for (int i = 0; i < 2; i++) begin
      c[i] = 1'b1; st[i] = 1'b1; w[i] = 1'b1; a[i] = AW'(10'h100 + i); d[i] = 8'($urandom);
    end
    for (int k = 0; k < 200 && seq.size() < 8; k++) begin
      tick();
      if (ob_gnt != 2'b00 && prev == 2'b00) seq.push_back(ob_gnt);
      prev = ob_gnt;
      for (int i = 0; i < 2; i++) begin
        c[i]  = !ob_ack[i];
        st[i] = !ob_ack[i];
      end
    end
    chk("alt_count", seq.size(), 8);
    cnt0 = 0;
    for (int k = 0; k < seq.size(); k++) begin
      chk($sformatf("alt_%0d", k), {30'd0, seq[k]}, (k % 2 == 0) ? 32'd1 : 32'd2);
      if (seq[k] == 2'b01) cnt0++;
    end
    chk("alt_m0_share", cnt0, 4);
    release_all();

    // m1 holds the bus for three writes while m0 waits
    c[1] = 1'b1; st[1] = 1'b1; w[1] = 1'b1; a[1] = 10'h3F0; d[1] = 8'h11;
    tick();
    c[0] = 1'b1; st[0] = 1'b1; w[0] = 1'b0; a[0] = 10'h3F0;
    wait_ack(1, lat);
    a[1] = 10'h3F1; d[1] = 8'h22;
    wait_ack(1, lat);
    a[1] = 10'h3F2; d[1] = 8'h33;
    wait_ack(1, lat);
    chk("hold_gnt_m1", {30'd0, ob_gnt}, 32'd2);
    c[1] = 1'b0; st[1] = 1'b0;
    wait_ack(0, lat);
    chk("hold_gnt_m0", {30'd0, ob_gnt}, 32'd1);
    chk("hold_rd0", {24'd0, ob_dat[0]}, 32'h11);
    a[0] = 10'h3F1;
    wait_ack(0, lat);
    chk("hold_rd1", {24'd0, ob_dat[0]}, 32'h22);
    a[0] = 10'h3F2;
    wait_ack(0, lat);
    chk("hold_rd2", {24'd0, ob_dat[0]}, 32'h33);
    release_all();

    // Watchdog abort with the slave stalled
    stall = 1'b1;
    c[0] = 1'b1; st[0] = 1'b1; w[0] = 1'b0; a[0] = 10'h001;
    tick();
    nstb = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (ob_sstb) nstb++;
      if (ob_err[0]) break;
    end
    chk("wd_err_seen", {31'd0, ob_err[0]}, 32'd1);
    chk("wd_err_cycle", nstb, TO);
    tick();
    chk("wd_stb_dropped", {31'd0, ob_sstb}, 32'd0);
    c[0] = 1'b0; st[0] = 1'b0;
    tick();
    tick();
    chk("wd_idle_gnt", {30'd0, ob_gnt}, 32'd0);

    // Ack landing on the final watchdog cycle suppresses the abort
    c[0] = 1'b1; st[0] = 1'b1;
    tick();
    tick();
    tick();
    stall = 1'b0;
    tick();
    tick();
    chk("wd_late_ack", {31'd0, ob_ack[0]}, 32'd1);
    chk("wd_late_noerr", {31'd0, ob_err[0]}, 32'd0);
    release_all();

    // Reset in the middle of a stalled m1 transfer
    stall = 1'b1;
    c[1] = 1'b1; st[1] = 1'b1; w[1] = 1'b1; a[1] = 10'h050; d[1] = 8'h5A;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    stall = 1'b0;
    c[0] = 1'b1; st[0] = 1'b1;
    tick();
    chk("rst_gnt", {30'd0, ob_gnt}, 32'd0);
    chk("rst_scyc", {31'd0, ob_scyc}, 32'd0);
    chk("rst_ack_err", {28'd0, ob_ack, ob_err}, 32'd0);
    tick();
    chk("rst_regrant", {30'd0, ob_gnt}, 32'd1);
    release_all();

    // Random traffic, checked cycle by cycle against the model
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < 2; i++) begin
        c[i]  = c[i] ? ($urandom % 8 != 0) : ($urandom % 3 == 0);
        st[i] = c[i] && ($urandom % 4 != 0);
        w[i]  = 1'($urandom);
        a[i]  = AW'($urandom);
        d[i]  = 8'($urandom);
      end
      if ($urandom % 5 == 0) stall = ~stall;
      rst = ($urandom % 80 == 0);
      tick();
    end
    rst = 1'b0;
    stall = 1'b0;
    release_all();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench did not finish");
  end

endmodule

// File: doc/spm_wb_arbiter.md
Name: spm_wb_arbiter

Overview:
Two-master, one-slave Wishbone arbiter that shares the byte-wide scratchpad memory between the CPU data port (master 0) and the cDMA engine (master 1). Round-robin grant, held for a whole bus cycle (CYC high). A per-transfer watchdog aborts stalled transfers with an error strobe. Sits between the masters and the scratchpad's Wishbone slave port; data, address and WE pass through combinationally once granted.

Parameters:
SPM_AWID, 10, address width of the scratchpad slave port
TIMEOUT, 16, max cycles STB may wait for ACK before abort; 0 disables the watchdog
TO_W, $clog2(TIMEOUT+1), watchdog counter width (derived)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
m0_adr_i  input  SPM_AWID  master 0 address
m0_dat_i  input  8  master 0 write data
m0_dat_o  output  8  master 0 read data
m0_we_i  input  1  master 0 write enable
m0_cyc_i  input  1  master 0 cycle / bus request
m0_stb_i  input  1  master 0 strobe
m0_ack_o  output  1  master 0 acknowledge
m0_err_o  output  1  master 0 timeout error, one-cycle pulse
m1_*  (same set as m0_*)  master 1 (cDMA)
s_adr_o  output  SPM_AWID  slave address
s_dat_o  output  8  slave write data
s_dat_i  input  8  slave read data
s_we_o  output  1  slave write enable
s_cyc_o  output  1  slave cycle
s_stb_o  output  1  slave strobe
s_ack_i  input  1  slave acknowledge
gnt_o  output  2  one-hot current grant, for debug/perf counters

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Registered state: state {IDLE, GRANT, ABORT}, owner (1 bit), last_owner (1 bit), wdog (TO_W bits).
- Reset: state=IDLE, owner=0, last_owner=1 (m0 wins the first contention), wdog=0. Outputs in the cycle after reset: gnt_o=0; s_cyc_o, s_stb_o, s_we_o=0; s_adr_o=0; s_dat_o=0; all mX_ack_o and mX_err_o=0; mX_dat_o=0.
- IDLE: slave outputs driven to 0. When any mX_cyc_i is high, load owner and go to GRANT at the next edge. Only one requester: grant it. Both: grant ~last_owner. Grant latency is 1 cycle from the first CYC.
- GRANT: gnt_o=onehot(owner). s_adr_o, s_dat_o, s_we_o, s_cyc_o and s_stb_o mux from the owner combinationally. Owner ack = s_ack_i; owner dat_o = s_dat_i. Non-owner ack, err and dat_o = 0.
- Slave ACK is the registered STB (1-cycle latency, ACK also qualified by CYC). Masters must drop or advance STB after ACK. The arbiter adds no latency to ACK.
- Release: owner cyc_i low in GRANT -> IDLE at the next edge, last_owner<=owner. One bubble cycle before the next grant. This gives fair alternation under continuous contention.
- Requests from the non-owner are ignored until release. No preemption.
- Watchdog (TIMEOUT>0), in GRANT:
  - wdog clears when owner stb is low or s_ack_i is high; otherwise it increments.
  - When wdog==TIMEOUT-1 and still no ack: pulse owner err_o for that cycle, go to ABORT, clear wdog.
- ABORT: s_stb_o=0, s_cyc_o=0, owner ack=0. Wait for owner cyc_i low, then IDLE with last_owner<=owner.
- s_ack_i arriving in the same cycle wdog hits TIMEOUT-1: ack wins, no err.
- s_ack_i while IDLE or ABORT: ignored, not routed.
- rst mid-transfer: dropped at the next edge, no ack/err emitted, slave writes stop; masters must restart.
- TIMEOUT=0: wdog held at 0, err_o is never asserted, ABORT is unreachable.

Test Plan:
- Single write/read: m0 writes 0xA5 to 0x005, then reads 0x005 -> gnt_o=01 one cycle after CYC; m0_ack_o one cycle after s_stb_o; read returns 0xA5; m1_ack_o stays 0.
- Simultaneous first request: m0, m1 raise CYC on the same cycle after reset -> m0 granted first. After m0 drops CYC: one idle bubble, then gnt_o=10.
- Continuous contention: both hold CYC/STB and each drops CYC after 1 ack, then re-requests immediately, for 8 transfers -> grants alternate m0,m1,m0,... with exactly 4 each.
- Hold/no preemption: m1 owns and performs 3 back-to-back writes (0x3F0..0x3F2 = 0x11,0x22,0x33) while m0 requests -> m0 waits; memory holds all three values; m0 is granted after m1 releases.
- Watchdog: TIMEOUT=4, slave ACK forced low, m0 STB held -> m0_err_o pulses exactly 4 cycles after s_stb_o rises; s_stb_o low next cycle; IDLE after m0 drops CYC. Repeat with ACK on the 4th cycle -> no err.
- Reset mid-transfer: assert rst while m1 STB is high -> next cycle gnt_o=0, s_cyc_o=0, no ack/err. After rst drops with both requesting -> m0 granted.
